// File: rtl/mips_cpu_fetch.sv
// ---------------------------------------------------------------------------
// mips_cpu_fetch
//   Instruction fetch stage for the multi-cycle MIPS core. Reads the word at
//   the current PC over Avalon-MM, latches it into the instruction register
//   (IR), and presents the decoded instruction fields while the instruction
//   executes. pc_stall holds the PC stage so that the PC advances exactly once
//   per executed instruction. A fetch from HALT_ADDR parks the stage in HALT;
//   a fetch from a misaligned PC parks it in ERR with a sticky fetch_error.
//
// Parameters
//   BYTE_SWAP    1: IR = byte-reversed readdata, 0: IR = readdata
//   EXEC_CYCLES  cycles the IR is presented valid per instruction (>= 1)
//   HALT_ADDR    PC value that halts the core instead of being fetched
//
// Ports
//   clk, reset         clock and synchronous active-high reset
//   pc                 current PC from the PC stage (stable while pc_stall=1)
//   address, read      Avalon read request (address is 0 when read=0)
//   waitrequest        Avalon stall; readdata valid when read=1 and this is 0
//   readdata           Avalon read data
//   instr              IR contents
//   opcode/rt/rd/sa/funct/offset/target   pure bit slices of the IR
//   instr_valid        1 while the instruction is executing
//   pc_stall           0 only on the last execute cycle (PC advances then)
//   active             0 once halted or faulted
//   fetch_error        sticky misaligned-fetch flag
// ---------------------------------------------------------------------------
module mips_cpu_fetch #(
  parameter int          BYTE_SWAP   = 0,
  parameter int          EXEC_CYCLES = 1,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  funct,
  output logic [15:0] offset,
  output logic [25:0] target,
  output logic        instr_valid,
  output logic        pc_stall,
  output logic        active,
  output logic        fetch_error
);

  localparam int             CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_ir;
  logic [31:0]   w_ir_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_fetch_error;
  logic          w_fetch_error_next;
  logic [31:0]   w_rdata_fmt;

  // Bus word as it should appear in the IR.
  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign w_rdata_fmt[8*gi +: 8] = readdata[8*(3-gi) +: 8];
      end
    end else begin : g_noswap
      assign w_rdata_fmt = readdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ir          <= 32'h0000_0000;
      r_cnt         <= '0;
      r_fetch_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ir          <= w_ir_next;
      r_cnt         <= w_cnt_next;
      r_fetch_error <= w_fetch_error_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_ir_next          = r_ir;
    w_cnt_next         = r_cnt;
    w_fetch_error_next = r_fetch_error;
    read               = 1'b0;
    address            = 32'h0000_0000;
    instr_valid        = 1'b0;
    pc_stall           = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        // Halt address wins over the alignment check.
        if (pc == HALT_ADDR) begin
          w_state_next = S_HALT;
        end else if (pc[1:0] != 2'b00) begin
          w_state_next       = S_ERR;
          w_fetch_error_next = 1'b1;
        end else begin
          read    = 1'b1;
          address = pc;
          if (!waitrequest) begin
            w_ir_next    = w_rdata_fmt;
            w_cnt_next   = '0;
            w_state_next = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        instr_valid = 1'b1;
        if (r_cnt == CNT_LAST) begin
          // Release the PC stage on this edge; the next FETCH sees the new PC.
          pc_stall     = 1'b0;
          w_state_next = S_FETCH;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_HALT: begin
        w_state_next = S_HALT;
      end

      S_ERR: begin
        w_state_next = S_ERR;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign active      = (r_state != S_HALT) && (r_state != S_ERR);
  assign fetch_error = r_fetch_error;

  assign instr  = r_ir;
  assign opcode = r_ir[31:26];
  assign rt     = r_ir[20:16];
  assign rd     = r_ir[15:11];
  assign sa     = r_ir[10:6];
  assign funct  = r_ir[5:0];
  assign offset = r_ir[15:0];
  assign target = r_ir[25:0];

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_fetch
//   Directed bench for mips_cpu_fetch. Two instances share clock, reset and
//   bus inputs: dut_a uses default parameters, dut_b uses BYTE_SWAP=1 and
//   EXEC_CYCLES=3. A vector table covers decode/address/swap of single
//   fetches; hand-written sequences cover waitrequest stretching, multi-cycle
//   execute, halt, misaligned fetch and reset during a pending read.
// ---------------------------------------------------------------------------
module tb_mips_cpu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] a_address, b_address;
  logic        a_read, b_read;
  logic [31:0] a_instr, b_instr;
  logic [5:0]  a_opcode, b_opcode;
  logic [4:0]  a_rt, b_rt, a_rd, b_rd, a_sa, b_sa;
  logic [5:0]  a_funct, b_funct;
  logic [15:0] a_offset, b_offset;
  logic [25:0] a_target, b_target;
  logic        a_valid, b_valid, a_stall, b_stall, a_active, b_active, a_ferr, b_ferr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_cpu_fetch dut_a (
    .clk(clk), .reset(reset), .pc(pc), .address(a_address), .read(a_read),
    .waitrequest(waitrequest), .readdata(readdata), .instr(a_instr),
    .opcode(a_opcode), .rt(a_rt), .rd(a_rd), .sa(a_sa), .funct(a_funct),
    .offset(a_offset), .target(a_target), .instr_valid(a_valid),
    .pc_stall(a_stall), .active(a_active), .fetch_error(a_ferr)
  );

  mips_cpu_fetch #(.BYTE_SWAP(1), .EXEC_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .address(b_address), .read(b_read),
    .waitrequest(waitrequest), .readdata(readdata), .instr(b_instr),
    .opcode(b_opcode), .rt(b_rt), .rd(b_rd), .sa(b_sa), .funct(b_funct),
    .offset(b_offset), .target(b_target), .instr_valid(b_valid),
    .pc_stall(b_stall), .active(b_active), .fetch_error(b_ferr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] swapped;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] offset;
    logic [25:0] target;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int bad;

    // addiu $2,$0,10 ; addu $2,$4,$5 ; lw $4,16($sp) ; sll $3,$3,3
    vecs[0] = '{32'hBFC0_0000, 32'h2402_000A, 32'h0A00_0224, 6'h09, 5'd2, 5'd0, 5'd0, 6'h0A, 16'h000A, 26'h002_000A};
    vecs[1] = '{32'hBFC0_0004, 32'h0085_1021, 32'h2110_8500, 6'h00, 5'd5, 5'd2, 5'd0, 6'h21, 16'h1021, 26'h085_1021};
    vecs[2] = '{32'h0040_0020, 32'h8FA4_0010, 32'h1000_A48F, 6'h23, 5'd4, 5'd0, 5'd0, 6'h10, 16'h0010, 26'h3A4_0010};
    vecs[3] = '{32'h1000_000C, 32'h0003_18C0, 32'hC018_0300, 6'h00, 5'd3, 5'd3, 5'd3, 6'h00, 16'h18C0, 26'h003_18C0};

    reset       = 1'b1;
    pc          = 32'h0;
    waitrequest = 1'b0;
    readdata    = 32'h0;

    // ---- table-driven single fetches -------------------------------------
    for (int i = 0; i < 4; i++) begin
      pc          = vecs[i].pc;
      readdata    = vecs[i].data;
      waitrequest = 1'b0;
      do_reset();
      // IDLE right after reset
      chk("rst_read",   {31'b0, a_read},   32'd0);
      chk("rst_addr",   a_address,         32'd0);
      chk("rst_instr",  a_instr,           32'd0);
      chk("rst_valid",  {31'b0, a_valid},  32'd0);
      chk("rst_stall",  {31'b0, a_stall},  32'd1);
      chk("rst_active", {31'b0, a_active}, 32'd1);
      chk("rst_ferr",   {31'b0, a_ferr},   32'd0);
      tick();
      // FETCH: one read cycle
      chk("fetch_read",  {31'b0, a_read},  32'd1);
      chk("fetch_addr",  a_address,        vecs[i].pc);
      chk("fetch_stall", {31'b0, a_stall}, 32'd1);
      chk("fetch_valid", {31'b0, a_valid}, 32'd0);
      chk("fetch_addr_b", b_address,       vecs[i].pc);
      tick();
      // EXEC (single cycle on dut_a)
      chk("exec_instr",  a_instr,          vecs[i].data);
      chk("exec_opcode", {26'b0, a_opcode}, {26'b0, vecs[i].opcode});
      chk("exec_rt",     {27'b0, a_rt},     {27'b0, vecs[i].rt});
      chk("exec_rd",     {27'b0, a_rd},     {27'b0, vecs[i].rd});
      chk("exec_sa",     {27'b0, a_sa},     {27'b0, vecs[i].sa});
      chk("exec_funct",  {26'b0, a_funct},  {26'b0, vecs[i].funct});
      chk("exec_offset", {16'b0, a_offset}, {16'b0, vecs[i].offset});
      chk("exec_target", {6'b0, a_target},  {6'b0, vecs[i].target});
      chk("exec_valid",  {31'b0, a_valid},  32'd1);
      chk("exec_stall",  {31'b0, a_stall},  32'd0);
      chk("exec_read",   {31'b0, a_read},   32'd0);
      chk("exec_addr",   a_address,         32'd0);
      chk("swap_instr",  b_instr,           vecs[i].swapped);
      $display("vec %0d: pc=%h readdata=%h instr=%h swapped=%h", i, vecs[i].pc, vecs[i].data, a_instr, b_instr);
    end

    // ---- waitrequest held for 3 cycles -----------------------------------
    pc          = 32'hBFC0_0000;
    readdata    = 32'hDEAD_BEEF;
    waitrequest = 1'b1;
    do_reset();
    tick();
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      chk("wait_read",  {31'b0, a_read},  32'd1);
      chk("wait_addr",  a_address,        32'hBFC0_0000);
      chk("wait_stall", {31'b0, a_stall}, 32'd1);
      chk("wait_instr", a_instr,          32'd0);
      if (c == 3) begin
        waitrequest = 1'b0;
        readdata    = 32'h2402_000A;
      end
      tick();
    end
    chk("wait_cap_instr", a_instr,          32'h2402_000A);
    chk("wait_cap_valid", {31'b0, a_valid}, 32'd1);
    if (a_stall == 1'b0) pulses++;
    // PC advances; next fetch is held off so no further release can occur.
    pc          = 32'hBFC0_0004;
    waitrequest = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_stall == 1'b0) pulses++;
    end
    chk("wait_pulses", pulses, 32'd1);
    chk("wait_next_addr", a_address, 32'hBFC0_0004);
    $display("waitrequest x3: release pulses=%0d", pulses);

    // ---- EXEC_CYCLES=3 with byte swap (dut_b) ----------------------------
    pc          = 32'hBFC0_0000;
    readdata    = 32'h0A00_0224;
    waitrequest = 1'b0;
    do_reset();
    tick();
    chk("x3_fetch_read", {31'b0, b_read}, 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("x3_instr", b_instr,          32'h2402_000A);
      chk("x3_valid", {31'b0, b_valid}, 32'd1);
      chk("x3_stall", {31'b0, b_stall}, (c == 2) ? 32'd0 : 32'd1);
      chk("x3_read",  {31'b0, b_read},  32'd0);
      if (c == 2) waitrequest = 1'b1;
      tick();
    end
    chk("x3_after_valid", {31'b0, b_valid}, 32'd0);
    chk("x3_after_stall", {31'b0, b_stall}, 32'd1);
    chk("x3_after_read",  {31'b0, b_read},  32'd1);
    $display("exec x3: instr=%h", b_instr);

    // ---- HALT at pc == 0 --------------------------------------------------
    pc          = 32'h0000_0000;
    waitrequest = 1'b0;
    readdata    = 32'h2402_000A;
    do_reset();
    tick();
    chk("halt_fetch_read",   {31'b0, a_read},   32'd0);
    chk("halt_fetch_active", {31'b0, a_active}, 32'd1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_read !== 1'b0 || a_active !== 1'b0 || a_stall !== 1'b1 || a_valid !== 1'b0 || a_instr !== 32'd0)
        bad++;
      if (c == 5) pc = 32'hBFC0_0000;
    end
    chk("halt_bad_cycles", bad, 32'd0);
    do_reset();
    chk("halt_rst_active", {31'b0, a_active}, 32'd1);
    chk("halt_rst_read",   {31'b0, a_read},   32'd0);
    tick();
    chk("halt_rst_fetch",  {31'b0, a_read},   32'd1);
    $display("halt: held 20 cycles, bad=%0d", bad);

    // ---- misaligned PC -> ERR --------------------------------------------
    pc = 32'hBFC0_0002;
    do_reset();
    tick();
    chk("err_fetch_read", {31'b0, a_read}, 32'd0);
    chk("err_fetch_ferr", {31'b0, a_ferr}, 32'd0);
    tick();
    chk("err_ferr",   {31'b0, a_ferr},   32'd1);
    chk("err_active", {31'b0, a_active}, 32'd0);
    pc  = 32'hBFC0_0000;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_ferr !== 1'b1 || a_read !== 1'b0 || a_stall !== 1'b1) bad++;
    end
    chk("err_sticky", bad, 32'd0);
    $display("misaligned: fetch_error=%0b bad=%0d", a_ferr, bad);

    // ---- reset during a pending read -------------------------------------
    pc          = 32'hBFC0_0000;
    readdata    = 32'h2402_000A;
    waitrequest = 1'b0;
    do_reset();
    tick();
    tick();
    chk("mid_pre_instr", a_instr, 32'h2402_000A);
    pc          = 32'hBFC0_0004;
    waitrequest = 1'b1;
    tick();
    chk("mid_pending_read", {31'b0, a_read}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_read",  {31'b0, a_read}, 32'd0);
    chk("mid_rst_instr", a_instr,         32'd0);
    // Late data arrives while still in reset/IDLE and must be ignored.
    waitrequest = 1'b0;
    readdata    = 32'hFFFF_FFFF;
    reset       = 1'b0;
    tick();
    chk("mid_late_instr", a_instr, 32'd0);
    $display("reset mid-read: read=%0b instr=%h", a_read, a_instr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
